// File: rtl/scoreboard_pkg.sv
// Shared register-id encoding for decode, forwarding and the hazard scoreboard.
// No logic; constants and helpers only.
// Not applicable.
package scoreboard_pkg;

  localparam int NBANK_DEF = 2;
  localparam int NREG_DEF  = 32;
  localparam int CNT_W_DEF = 5;
  localparam int BANK_W    = $clog2(NBANK_DEF);
  localparam int IDX_W     = $clog2(NREG_DEF);

  localparam logic [BANK_W-1:0] BANK_GPR = 0;
  localparam logic [BANK_W-1:0] BANK_FPR = 1;

  // Register id as seen by decode: bank in the upper bits, index below.
  typedef struct packed {
    logic [BANK_W-1:0] bank;
    logic [IDX_W-1:0]  idx;
  } rid_t;

  function automatic rid_t mk_rid(input logic [BANK_W-1:0] bank, input logic [IDX_W-1:0] idx);
    rid_t r;
    r.bank = bank;
    r.idx  = idx;
    return r;
  endfunction

endpackage

// File: rtl/sb_entry.sv
// One tracked register: forwarding-latency countdown plus write-outstanding flag.
// State visible one cycle after load/clear; countdown steps once per cycle.
// No backpressure; flush beats load, load beats decrement and writeback clear.
module sb_entry #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             pend
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  // Countdown and pending flag; an issue in the same cycle as its own writeback keeps pend set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt  <= '0;
      pend <= 1'b0;
    end else if (flush) begin
      cnt  <= '0;
      pend <= 1'b0;
    end else begin
      if (load)
        cnt <= load_val;
      else if (cnt != '0)
        cnt <= cnt - CNT_ONE;

      if (load)
        pend <= 1'b1;
      else if (clr)
        pend <= 1'b0;
    end
  end

endmodule

// File: rtl/scoreboard.sv
// Per-register in-flight write tracking for decode; resolves RAW/WAW stalls.
// stall is combinational in the issue cycle; pending/inflight update at the next edge.
// issue_ready = !stall; writeback and flush are always accepted.
module scoreboard
  import scoreboard_pkg::*;
#(
  parameter  int NBANK   = 2,
  parameter  int NREG    = 32,
  parameter  int CNT_W   = 5,
  parameter  bit ZERO_R0 = 1'b1,
  localparam int RID_W   = $clog2(NBANK) + $clog2(NREG),
  localparam int NTOT    = NBANK * NREG,
  localparam int IF_W    = $clog2(NBANK * NREG + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic             issue_use_s,
  input  logic             issue_use_t,
  input  logic [RID_W-1:0] issue_rs,
  input  logic [RID_W-1:0] issue_rt,
  input  logic             issue_wen,
  input  logic [RID_W-1:0] issue_rd,
  input  logic [CNT_W-1:0] issue_wait,
  input  logic             wb_valid,
  input  logic [RID_W-1:0] wb_rd,
  input  logic             flush,
  output logic             stall,
  output logic [NTOT-1:0]  pending,
  output logic [IF_W-1:0]  inflight
);

  localparam int IDX_BITS = $clog2(NREG);
  localparam int NID      = 2 ** RID_W;
  localparam logic [IF_W-1:0] IF_ONE = 1;
  localparam logic [IF_W-1:0] IF_MAX = IF_W'(NTOT);

  logic [CNT_W-1:0] cnt_a [NID];
  logic [NID-1:0]   pend_a;
  logic [NID-1:0]   trk;
  logic [NID-1:0]   load_en;
  logic [NID-1:0]   clr_en;
  logic             accept;
  logic             rd_wr;
  logic             inc;
  logic             dec;

  // Id space is sparse when NBANK/NREG are not powers of two; holes read as idle.
  for (genvar g = 0; g < NID; g++) begin : g_ent
    localparam bit VALID = ((g >> IDX_BITS) < NBANK) && ((g % (2 ** IDX_BITS)) < NREG);
    assign trk[g] = (VALID && !(ZERO_R0 && (g == 0))) ? 1'b1 : 1'b0;
    if (VALID) begin : g_v
      sb_entry #(.CNT_W(CNT_W)) u_ent (
        .clk      (clk),
        .rstn     (rstn),
        .flush    (flush),
        .load     (load_en[g]),
        .load_val (issue_wait),
        .clr      (clr_en[g]),
        .cnt      (cnt_a[g]),
        .pend     (pend_a[g])
      );
    end else begin : g_nv
      assign cnt_a[g]  = '0;
      assign pend_a[g] = 1'b0;
    end
  end

  for (genvar i = 0; i < NTOT; i++) begin : g_pend
    localparam int ID = ((i / NREG) * (2 ** IDX_BITS)) + (i % NREG);
    assign pending[i] = pend_a[ID];
  end

  // Hazard check: sources must have no outstanding latency, and a new write may not overtake an older one.
  always_comb begin
    stall = 1'b0;
    if (issue_valid) begin
      if (issue_use_s && (cnt_a[issue_rs] != '0))
        stall = 1'b1;
      if (issue_use_t && (cnt_a[issue_rt] != '0))
        stall = 1'b1;
      if (issue_wen && (cnt_a[issue_rd] > issue_wait))
        stall = 1'b1;
    end
  end

  assign issue_ready = !stall;
  assign accept      = issue_valid && !stall;
  assign rd_wr       = accept && issue_wen && trk[issue_rd];

  // Id decode into one-hot load and writeback-clear strobes.
  always_comb begin
    load_en = '0;
    clr_en  = '0;
    if (rd_wr)
      load_en[issue_rd] = 1'b1;
    if (wb_valid)
      clr_en[wb_rd] = 1'b1;
  end

  // A writeback only counts if it really clears a bit, i.e. the same-id issue does not re-arm it.
  assign inc = rd_wr && !pend_a[issue_rd];
  assign dec = wb_valid && pend_a[wb_rd] && !(rd_wr && (issue_rd == wb_rd));

  // Running count of set pending bits, saturating at both ends.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      inflight <= '0;
    else if (flush)
      inflight <= '0;
    else if (inc && !dec && (inflight != IF_MAX))
      inflight <= inflight + IF_ONE;
    else if (dec && !inc && (inflight != '0))
      inflight <= inflight - IF_ONE;
  end

endmodule

// File: doc/scoreboard.md
# scoreboard

Parametrised register scoreboard for the decode stage. It replaces the single fixed-latency branch/jump hazard flag with per-register tracking of in-flight writes across several register banks (GPR, FPR, and any later bank). Decode presents each instruction's source and destination operands. The block answers with a one-cycle-resolved stall and records the producer's latency, so that multi-cycle FPU and load results are never consumed early. Writeback clears the pending state.

## Interface
- `NBANK`, default 2: number of register banks (bank 0 = GPR, bank 1 = FPR).
- `NREG`, default 32: registers per bank.
- `CNT_W`, default 5: width of the latency counter; matches decode's `wait_time`.
- `ZERO_R0`, default 1: when 1, bank 0 register 0 is never tracked.
- Register id width: `RID_W` = $clog2(NBANK) + $clog2(NREG). Encoding is {bank, index}.
- Ports:
  - `clk` in 1: single clock.
  - `rstn` in 1: reset, asynchronous, active-low.
  - `issue_valid` in 1: decode presents an instruction.
  - `issue_ready` out 1: instruction may advance; equals !`stall`.
  - `issue_use_s` / `issue_use_t` in 1: source s / t is read.
  - `issue_rs` / `issue_rt` in `RID_W`: source register ids.
  - `issue_wen` in 1: instruction writes a register.
  - `issue_rd` in `RID_W`: destination id.
  - `issue_wait` in `CNT_W`: cycles before the result becomes forwardable (0 = forwardable next cycle).
  - `wb_valid` in 1: writeback commits to the register file.
  - `wb_rd` in `RID_W`: writeback destination.
  - `flush` in 1: synchronous discard of all tracking (mispredict/restart).
  - `stall` out 1: combinational hazard for the presented instruction.
  - `pending` out `NBANK*NREG`: per-register "write outstanding" bits, bit index = id.
  - `inflight` out $clog2(NBANK*NREG+1): population count of `pending`, registered.

## Operation
- Per register: `cnt` (`CNT_W`) and `pend` (1 bit).
- `stall` is 1 when `issue_valid` is asserted and any of the following holds:
  - `issue_use_s` and `cnt[rs]` != 0 (RAW on s).
  - `issue_use_t` and `cnt[rt]` != 0 (RAW on t).
  - `issue_wen` and `cnt[rd]` > `issue_wait` (WAW: a younger result must not complete first).
- Untracked id (bank 0, index 0, with `ZERO_R0`=1) never contributes to `stall` and is never set.
- Accept = `issue_valid` & !`stall`. On accept with `issue_wen`:
  - `cnt[rd]` <= `issue_wait`.
  - `pend[rd]` <= 1.
- Every non-loaded `cnt` that is nonzero decrements by 1 per cycle and saturates at 0.
- `wb_valid` clears `pend[wb_rd]`. A writeback to a non-pending register is ignored.
- Same cycle, accepted issue and `wb_valid` to the same id: the issue wins; `pend` stays 1 and `inflight` is unchanged.
- `flush` has priority over issue and writeback. It clears every `cnt`, every `pend`, and `inflight` at the next edge.
- `inflight` update rule:
  - +1 on accepted issue to a non-pending id.
  - -1 on effective writeback.
  - Net 0 when both occur on distinct ids.
  - Never wraps.

## Timing
- Reset (async assert, sync deassert by the surrounding design): all `cnt`=0, `pending`=0, `inflight`=0. Consequently `stall`=0 and `issue_ready`=1 whenever `issue_valid`=0.
- `stall` is combinational from issue inputs and registered state; there is no state-to-state combinational path.
- Producer accepted in cycle t with `issue_wait`=N:
  - A dependent consumer stalls in cycles t+1 .. t+N.
  - It is accepted in cycle t+N+1.
  - For N=0 it is accepted in t+1.
- Reset asserted mid-operation discards all tracking immediately; no writeback is expected afterwards.

## Structure
- Add the following to the shared `constant` package, so decode and forwarding share the encoding:
  - `BANK_GPR` and `BANK_FPR` constants.
  - The `rid_t` typedef, {bank, index}.
- One sub-module, `sb_entry`, instantiated `NBANK*NREG` times via generate. It holds the `cnt`/`pend` pair and implements the load, decrement, clear and flush priorities.
- The top level contains the stall compare, the id decode to one-hot load/clear enables, and the `inflight` counter.

## Test plan
- Reset, then issue `rd`=GPR5 with `wait`=2 at cycle 0; consumer reads GPR5 -> `stall`=1 in cycles 1-2, accepted in cycle 3; `pending[5]`=1 and `inflight`=1 until `wb_rd`=5, then both 0.
- Issue to GPR0 with `ZERO_R0`=1, `wait`=5 -> no pending bit, `inflight` stays 0, a consumer of GPR0 never stalls.
- FPR3 (id 35) in flight with `cnt`=4; new issue writes FPR3 with `wait`=2 -> `stall`=1 until `cnt`≤2, then accepted and `cnt`=2.
- Issue to GPR7 and `wb_valid` to GPR7 in the same cycle while GPR7 is pending -> `pend[7]` remains 1, `inflight` unchanged.
- Three writes in flight, assert `flush` together with an issuing instruction -> next cycle `pending`=0, `inflight`=0, and the issue is not recorded.
- Assert `rstn`=0 asynchronously mid-countdown -> outputs zero before the next clock edge, and `stall`=0 once released.
